// File: rtl/axi_stream_demux.sv
// ---------------------------------------------------------------------------
// axi_stream_demux
// 1-to-2 valid/ready stream demultiplexer with packet-granular routing.
// The destination is chosen from sel on the first beat of a packet and held
// until the last beat. Each output has an output register plus one skid
// register, so every output is driven from a flop.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   sel                    route request (0 = a, 1 = b), used on packet start
//   s_valid/s_data/s_last  upstream beat
//   s_ready                upstream ready (skid-empty flag of routed channel)
//   a_valid/a_data/a_last  output a beat, a_ready downstream ready
//   b_valid/b_data/b_last  output b beat, b_ready downstream ready
//   a_pkt_cnt, b_pkt_cnt   packets delivered per output (optional)
//
// Optional feature: define STREAM_DEMUX_PKT_CNT_EN to add the 16-bit
// per-output packet counters.
// ---------------------------------------------------------------------------

// Output register plus one skid register for one channel.
module axi_stream_demux_skid #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_acc,
  input  logic [DATA_WD-1:0] i_data,
  input  logic               i_last,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [DATA_WD-1:0] o_data,
  output logic               o_last,
  output logic               o_skid_empty
);

  logic               r_valid;
  logic [DATA_WD-1:0] r_data;
  logic               r_last;
  logic [DATA_WD-1:0] r_skid_data;
  logic               r_skid_last;
  logic               r_skid_empty;
  logic               w_drain;

  assign w_drain = r_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_empty <= 1'b1;
    end else if (w_drain) begin
      if (!r_skid_empty) begin
        // skid moves forward; a same-cycle accept refills the skid slot
        r_data  <= r_skid_data;
        r_last  <= r_skid_last;
        r_valid <= 1'b1;
        if (i_acc) begin
          r_skid_data <= i_data;
          r_skid_last <= i_last;
        end else begin
          r_skid_empty <= 1'b1;
        end
      end else if (i_acc) begin
        r_data  <= i_data;
        r_last  <= i_last;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (!r_valid) begin
      if (i_acc) begin
        r_data  <= i_data;
        r_last  <= i_last;
        r_valid <= 1'b1;
      end
    end else if (i_acc) begin
      // output is stalled: park the beat in the skid register
      r_skid_data  <= i_data;
      r_skid_last  <= i_last;
      r_skid_empty <= 1'b0;
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_last       = r_last;
  assign o_skid_empty = r_skid_empty;

endmodule

// Route FSM
//   state  | meaning
//   IDLE   | no packet open; route follows sel
//   LOCKED | packet open; route held in r_route, sel ignored
module axi_stream_demux #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel,
  input  logic               s_valid,
  input  logic [DATA_WD-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               a_valid,
  output logic [DATA_WD-1:0] a_data,
  output logic               a_last,
  input  logic               a_ready,
  output logic               b_valid,
  output logic [DATA_WD-1:0] b_data,
  output logic               b_last,
`ifdef STREAM_DEMUX_PKT_CNT_EN
  input  logic               b_ready,
  output logic [15:0]        a_pkt_cnt,
  output logic [15:0]        b_pkt_cnt
`else
  input  logic               b_ready
`endif
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_route;
  logic   w_route_nxt;
  logic   w_route;
  logic   w_fire;
  logic   w_a_skid_empty;
  logic   w_b_skid_empty;

  assign w_route = (r_state == ST_IDLE) ? sel : r_route;
  assign s_ready = w_route ? w_b_skid_empty : w_a_skid_empty;
  assign w_fire  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_route <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_route_nxt = r_route;
    if (w_fire) begin
      case (r_state)
        ST_IDLE: begin
          if (!s_last) begin
            w_route_nxt = sel;
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (s_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  axi_stream_demux_skid #(.DATA_WD(DATA_WD)) u_skid_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_acc        (w_fire && !w_route),
    .i_data       (s_data),
    .i_last       (s_last),
    .i_ready      (a_ready),
    .o_valid      (a_valid),
    .o_data       (a_data),
    .o_last       (a_last),
    .o_skid_empty (w_a_skid_empty)
  );

  axi_stream_demux_skid #(.DATA_WD(DATA_WD)) u_skid_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_acc        (w_fire && w_route),
    .i_data       (s_data),
    .i_last       (s_last),
    .i_ready      (b_ready),
    .o_valid      (b_valid),
    .o_data       (b_data),
    .o_last       (b_last),
    .o_skid_empty (w_b_skid_empty)
  );

`ifdef STREAM_DEMUX_PKT_CNT_EN
  logic [15:0] r_a_pkt_cnt;
  logic [15:0] r_b_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_pkt_cnt <= '0;
      r_b_pkt_cnt <= '0;
    end else begin
      if (a_valid && a_ready && a_last) r_a_pkt_cnt <= r_a_pkt_cnt + 16'd1;
      if (b_valid && b_ready && b_last) r_b_pkt_cnt <= r_b_pkt_cnt + 16'd1;
    end
  end

  assign a_pkt_cnt = r_a_pkt_cnt;
  assign b_pkt_cnt = r_b_pkt_cnt;
`endif

endmodule

// File: doc/axi_stream_demux.md
Name: axi_stream_demux

Overview:
- 1-to-2 valid/ready stream demultiplexer; the receive-side counterpart of stream_mux.
- Routes one upstream stream (s_*) to output a or b, with packet-granular routing: the destination is latched on the first beat of a packet and held until its last beat.
- Each output has a registered skid stage (output register plus one skid register), so every m_* output is driven from a flop.
- Sits between a shared link and two downstream consumers.

Parameters:
- DATA_WD, 4, data width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sel  input  1  route request: 0 = output a, 1 = output b. Sampled only on packet-start beats.
- s_valid  input  1  upstream valid.
- s_data  input  DATA_WD  upstream data.
- s_last  input  1  upstream end-of-packet marker.
- s_ready  output  1  upstream ready.
- a_valid  output  1  output a valid.
- a_data  output  DATA_WD  output a data.
- a_last  output  1  output a end-of-packet.
- a_ready  input  1  output a ready.
- b_valid  output  1  output b valid.
- b_data  output  DATA_WD  output b data.
- b_last  output  1  output b end-of-packet.
- b_ready  input  1  output b ready.

Behaviour:
- Reset values: a_valid = b_valid = 0, a_data = b_data = 0, a_last = b_last = 0. Route FSM in IDLE, route_q = 0, both skid registers empty.
- Route FSM has two states:
  - IDLE: no packet open. Effective route = sel (combinational).
  - LOCKED: effective route = route_q; sel is ignored.
- FSM transitions, on an accepted beat (s_fire = s_valid && s_ready):
  - IDLE with s_last = 0: route_q <= sel, go to LOCKED.
  - IDLE with s_last = 1: single-beat packet; stay in IDLE.
  - LOCKED with s_last = 1: go to IDLE.
  - LOCKED with s_last = 0: stay in LOCKED.
- Ready: s_ready = skid-empty flag of the effective-route channel. That flag is registered, so s_ready depends combinationally only on sel (in IDLE) and flops.
- The unselected channel never gates s_ready. A stalled b does not block a packet routed to a.
- Per-channel skid stage (identical for a and b):
  - An accepted beat goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output drains (x_valid && x_ready) and the skid register is full, skid moves into the output register in the same edge.
  - Skid-empty flag clears when the skid register loads and sets when it unloads.
- Latency: 1 cycle from s_fire to x_valid.
- Throughput: one beat per cycle per output when x_ready is held high.
- Ordering: beat order is preserved per output. data and last travel together.
- Output stability: while x_valid = 1 and x_ready = 0, x_data and x_last must not change.
- Simultaneous events: a drain and an accept on the same channel in the same cycle keep the pipeline full and lose no beat. A last beat and the next packet's first beat on consecutive cycles route independently, with no bubble.
- sel changes while LOCKED: no effect until the FSM returns to IDLE.
- Reset mid-packet: all state clears, buffered beats are discarded, outputs drop to 0 asynchronously, and the FSM restarts in IDLE.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_CNT_EN.
- When defined:
  - Adds output ports a_pkt_cnt[15:0] and b_pkt_cnt[15:0], both reset to 0.
  - A counter increments on each x_valid && x_ready && x_last at its own output.
  - Counters wrap 16'hFFFF -> 0.
- When undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Single-beat routing: sel = 0, send data 4'h3 with last = 1, a_ready = 1 -> a_valid high one cycle later with a_data = 3, a_last = 1; b_valid stays 0.
- Packet lock: sel = 1 at beat 0 of a 4-beat packet 0,1,2,3, then sel = 0 for beats 1-3 -> all four beats appear on b in order, last only on beat 3; a_valid stays 0.
- Back-pressure: route to a with a_ready = 0 and 3 beats offered -> 2 accepted (output + skid), s_ready = 0 on the third. Raise a_ready -> beats emerge in order with no loss or duplication.
- Independence: b stalled with a full skid stage, next packet with sel = 0 -> s_ready = 1 and the a traffic flows at one beat per cycle.
- Random stress: random s_valid, a_ready, b_ready and sel over 5000 cycles -> scoreboard matches each packet's beats on its routed output, in order, and data is stable while stalled.
- Reset mid-packet: assert rst_n = 0 during beat 2 of a packet -> outputs go to 0 immediately; after release the next packet routes by the current sel. With STREAM_DEMUX_PKT_CNT_EN, counters read 0 after reset and 1 after one packet per output.
